// File: rtl/jtag_user_dr.sv
// rtl/jtag_user_dr.sv - user data register behind a JTAG TAP with length-checked update and RTI execute strobe
// Capture/shift/update follow the TAP DR states; update and exec strobes are registered one-cycle pulses.
module jtag_user_dr #(
  parameter int WIDTH       = 8,
  parameter int CAPTURE_SEL = 0,
  parameter int STRICT_LEN  = 1
) (
  input  logic             JTCK,
  input  logic             JRST,
  input  logic             JTDI,
  input  logic             JCE,
  input  logic             JSHIFT,
  input  logic             JUPDATE,
  input  logic             JRTI,
  input  logic [WIDTH-1:0] status_in,
  output logic             JTDO,
  output logic [WIDTH-1:0] data_out,
  output logic             update_pulse,
  output logic             exec_pulse,
  output logic             len_error
);

  localparam int CW = $clog2(WIDTH + 2);
  localparam logic [CW-1:0] CNT_FULL = CW'(WIDTH);
  localparam logic [CW-1:0] CNT_SAT  = CW'(WIDTH + 1);

  logic [WIDTH-1:0] shift_reg_q, shift_reg_d;
  logic [WIDTH-1:0] data_out_q, data_out_d;
  logic [CW-1:0]    bit_cnt_q, bit_cnt_d;
  logic             armed_q, armed_d;
  logic             exec_pending_q, exec_pending_d;
  logic             update_pulse_q, update_pulse_d;
  logic             exec_pulse_q, exec_pulse_d;
  logic             len_error_q, len_error_d;

  logic capture, shift, upd_seen, len_ok, accept, reject;

  always_comb begin
    capture  = JCE && !JSHIFT;
    shift    = JCE && JSHIFT;
    upd_seen = JUPDATE && armed_q;
    len_ok   = (STRICT_LEN == 0) || (bit_cnt_q == CNT_FULL);
    accept   = upd_seen && len_ok;
    reject   = upd_seen && !len_ok;
  end

  always_comb begin
    shift_reg_d    = shift_reg_q;
    bit_cnt_d      = bit_cnt_q;
    armed_d        = armed_q;
    data_out_d     = data_out_q;
    exec_pending_d = exec_pending_q;
    update_pulse_d = 1'b0;
    exec_pulse_d   = 1'b0;
    len_error_d    = len_error_q;

    // The update decision uses pre-edge shift_reg/bit_cnt, so a concurrent capture/shift cannot disturb it.
    if (accept) begin
      data_out_d     = shift_reg_q;
      update_pulse_d = 1'b1;
      len_error_d    = 1'b0;
    end else if (reject) begin
      len_error_d = 1'b1;
    end

    if (upd_seen) begin
      armed_d = 1'b0;
    end

    if (capture) begin
      shift_reg_d = (CAPTURE_SEL == 1) ? status_in : data_out_q;
      bit_cnt_d   = '0;
      armed_d     = 1'b1;
    end else if (shift) begin
      shift_reg_d = {JTDI, shift_reg_q[WIDTH-1:1]};
      if (bit_cnt_q != CNT_SAT) begin
        bit_cnt_d = bit_cnt_q + 1'b1;
      end
    end

    // An update landing with JRTI defers the execute strobe to the next JRTI cycle.
    if (accept) begin
      exec_pending_d = 1'b1;
    end else if (JRTI && exec_pending_q) begin
      exec_pending_d = 1'b0;
      exec_pulse_d   = 1'b1;
    end
  end

  always_ff @(posedge JTCK) begin
    if (JRST) begin
      shift_reg_q    <= '0;
      data_out_q     <= '0;
      bit_cnt_q      <= '0;
      armed_q        <= 1'b0;
      exec_pending_q <= 1'b0;
      update_pulse_q <= 1'b0;
      exec_pulse_q   <= 1'b0;
      len_error_q    <= 1'b0;
    end else begin
      shift_reg_q    <= shift_reg_d;
      data_out_q     <= data_out_d;
      bit_cnt_q      <= bit_cnt_d;
      armed_q        <= armed_d;
      exec_pending_q <= exec_pending_d;
      update_pulse_q <= update_pulse_d;
      exec_pulse_q   <= exec_pulse_d;
      len_error_q    <= len_error_d;
    end
  end

  assign JTDO         = shift_reg_q[0];
  assign data_out     = data_out_q;
  assign update_pulse = update_pulse_q;
  assign exec_pulse   = exec_pulse_q;
  assign len_error    = len_error_q;

endmodule

// File: tb/tb_jtag_user_dr.sv
// tb/tb_jtag_user_dr.sv - scoreboard bench for jtag_user_dr (readback and status-capture instances)
module tb_jtag_user_dr;

  logic       clk = 1'b0;
  logic       rst, tdi, ce, shf, upd, rti;
  logic [7:0] status;
  logic       tdo0, tdo1;
  logic [7:0] dout0, dout1;
  logic       up0, up1, ex0, ex1, le0, le1;

  int n_chk  = 0;
  int n_pass = 0;

  logic exp_q0[$];
  logic exp_q1[$];

  always #5 clk = ~clk;

  jtag_user_dr #(.WIDTH(8), .CAPTURE_SEL(0), .STRICT_LEN(1)) dut0 (
    .JTCK(clk), .JRST(rst), .JTDI(tdi), .JCE(ce), .JSHIFT(shf), .JUPDATE(upd), .JRTI(rti),
    .status_in(status), .JTDO(tdo0), .data_out(dout0), .update_pulse(up0),
    .exec_pulse(ex0), .len_error(le0)
  );

  jtag_user_dr #(.WIDTH(8), .CAPTURE_SEL(1), .STRICT_LEN(1)) dut1 (
    .JTCK(clk), .JRST(rst), .JTDI(tdi), .JCE(ce), .JSHIFT(shf), .JUPDATE(upd), .JRTI(rti),
    .status_in(status), .JTDO(tdo1), .data_out(dout1), .update_pulse(up1),
    .exec_pulse(ex1), .len_error(le1)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    ce = 0; shf = 0; upd = 0; tdi = 0;
  endtask

  task automatic capture();
    ce = 1; shf = 0; upd = 0;
    step();
    idle();
  endtask

  task automatic shift_bits(input logic [7:0] val, input int n);
    for (int i = 0; i < n; i++) begin
      ce = 1; shf = 1; tdi = val[i % 8];
      step();
    end
    idle();
  endtask

  task automatic update(input logic with_rti);
    upd = 1; rti = with_rti;
    step();
    upd = 0;
  endtask

  initial begin
    rst = 1; rti = 0; status = 8'h81;
    idle();
    step();
    chk("rst_dout", 64'(dout0), 64'h0);
    chk("rst_tdo", 64'(tdo0), 64'h0);
    chk("rst_up", 64'(up0), 64'h0);
    chk("rst_ex", 64'(ex0), 64'h0);
    chk("rst_le", 64'(le0), 64'h0);
    rst = 0;

    capture();
    shift_bits(8'hA5, 8);
    update(1'b0);
    chk("a5_dout", 64'(dout0), 64'hA5);
    chk("a5_up", 64'(up0), 64'h1);
    chk("a5_le", 64'(le0), 64'h0);
    step();
    chk("a5_up_one", 64'(up0), 64'h0);

    for (int i = 0; i < 3; i++) begin
      step();
      chk("idle_ex", 64'(ex0), 64'h0);
    end
    rti = 1;
    for (int i = 0; i < 4; i++) begin
      step();
      chk($sformatf("rti_ex%0d", i), 64'(ex0), (i == 0) ? 64'h1 : 64'h0);
    end
    rti = 0;

    update(1'b0);
    chk("noarm_up", 64'(up0), 64'h0);
    chk("noarm_dout", 64'(dout0), 64'hA5);

    capture();
    begin
      logic [7:0] rb, st;
      rb = 8'hA5;
      st = 8'h81;
      for (int i = 0; i < 8; i++) begin
        exp_q0.push_back(rb[i]);
        exp_q1.push_back(st[i]);
      end
    end
    for (int i = 0; i < 8; i++) begin
      chk($sformatf("rb_tdo%0d", i), 64'(tdo0), 64'(exp_q0.pop_front()));
      chk($sformatf("st_tdo%0d", i), 64'(tdo1), 64'(exp_q1.pop_front()));
      shift_bits(8'h00, 1);
    end

    capture();
    shift_bits(8'h3C, 7);
    update(1'b0);
    chk("short_dout", 64'(dout0), 64'hA5);
    chk("short_le", 64'(le0), 64'h1);
    chk("short_up", 64'(up0), 64'h0);

    capture();
    shift_bits(8'h3C, 8);
    update(1'b1);
    chk("3c_dout", 64'(dout0), 64'h3C);
    chk("3c_le", 64'(le0), 64'h0);
    chk("3c_up", 64'(up0), 64'h1);
    chk("3c_ex_same", 64'(ex0), 64'h0);
    step();
    chk("3c_ex_next", 64'(ex0), 64'h1);
    rti = 0;
    step();
    chk("3c_ex_once", 64'(ex0), 64'h0);

    capture();
    shift_bits(8'hFF, 10);
    update(1'b0);
    chk("long_le", 64'(le0), 64'h1);
    chk("long_dout", 64'(dout0), 64'h3C);

    capture();
    shift_bits(8'hFF, 4);
    ce = 1; shf = 1; tdi = 1; rst = 1;
    step();
    idle();
    rst = 0;
    chk("jrst_dout", 64'(dout0), 64'h0);
    chk("jrst_tdo", 64'(tdo0), 64'h0);
    chk("jrst_le", 64'(le0), 64'h0);
    chk("jrst_up", 64'(up0), 64'h0);
    chk("jrst_ex", 64'(ex0), 64'h0);
    update(1'b0);
    chk("jrst_upd_up", 64'(up0), 64'h0);
    chk("jrst_upd_dout", 64'(dout0), 64'h0);
    chk("jrst_upd_le", 64'(le0), 64'h0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
